// File: rtl/pixel_pkg.sv
// Shared types for the pixel board driver: board layout and FSM states.
`timescale 1ns/1ps
package pixel_pkg;
  localparam int BOARD_DIM = 8;

  typedef logic [BOARD_DIM-1:0][BOARD_DIM-1:0] board_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } drv_state_e;
endpackage

// File: rtl/pixel_board_driver_row_scanner.sv
// Matrix row scanner: one-hot row rotation every SCAN_CYCLES plus the row data mux.
`timescale 1ns/1ps
module row_scanner
  import pixel_pkg::*;
#(
  parameter int SCAN_CYCLES = 50_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  board_t               board,
  output logic [BOARD_DIM-1:0] row_select,
  output logic [BOARD_DIM-1:0] row_data
);
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [SW-1:0] scan_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt   <= '0;
      row_select <= BOARD_DIM'(1);
    end else if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
      scan_cnt   <= '0;
      row_select <= {row_select[BOARD_DIM-2:0], row_select[BOARD_DIM-1]};
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Combinational so a fresh commit appears on the active row immediately.
  always_comb begin
    row_data = '0;
    for (int i = 0; i < BOARD_DIM; i++)
      if (row_select[i]) row_data = row_data | board[i];
  end
endmodule

// File: rtl/pixel_board_driver.sv
// Key-to-step FSM with auto-repeat, single-lit-pixel board register and matrix scan.
`timescale 1ns/1ps
module pixel_board_driver
  import pixel_pkg::*;
#(
  parameter int REPEAT_CYCLES = 25_000_000,
  parameter int SCAN_CYCLES   = 50_000,
  parameter int START_X       = 0,
  parameter int START_Y       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 l_key,
  input  logic                 r_key,
  input  logic [7:0]           next_x,
  input  logic [7:0]           next_y,
  output logic                 l,
  output logic                 r,
  output board_t               pixel_board,
  output logic [BOARD_DIM-1:0] row_select,
  output logic [BOARD_DIM-1:0] row_data
);
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [2:0] SX = 3'(START_X);
  localparam logic [2:0] SY = 3'(START_Y);

  drv_state_e    state;
  logic [RW-1:0] rpt_cnt;
  logic          step_left;   // which key owns the current press
  logic          held, other;

  assign held  = step_left ? l_key : r_key;
  assign other = step_left ? r_key : l_key;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rpt_cnt     <= '0;
      step_left   <= 1'b0;
      l           <= 1'b0;
      r           <= 1'b0;
      pixel_board <= '0;
      pixel_board[SY][SX] <= 1'b1;
    end else begin
      case (state)
        IDLE: if (l_key ^ r_key) begin
          state     <= STEP;
          step_left <= l_key;
          l         <= l_key;
          r         <= r_key;
        end
        STEP: begin
          l       <= 1'b0;
          r       <= 1'b0;
          state   <= HOLD;
          rpt_cnt <= RW'(REPEAT_CYCLES - 1);
          // Out-of-range answers keep the old pixel so one bit always stays lit.
          if (next_x < 8'(BOARD_DIM) && next_y < 8'(BOARD_DIM)) begin
            pixel_board <= '0;
            pixel_board[next_y[2:0]][next_x[2:0]] <= 1'b1;
          end
        end
        HOLD: begin
          if (!held || other) begin
            state <= IDLE;
          end else if (rpt_cnt == '0) begin
            state <= STEP;
            l     <= step_left;
            r     <= !step_left;
          end else begin
            rpt_cnt <= rpt_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  row_scanner #(.SCAN_CYCLES(SCAN_CYCLES)) u_scan (
    .clk        (clk),
    .reset      (reset),
    .board      (pixel_board),
    .row_select (row_select),
    .row_data   (row_data)
  );
endmodule
